// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: word type, write-back codes, phase numbers and
// phase-sequencer state encodings.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wr_code_t;

  localparam wr_code_t WR_NONE = 4'd0;
  localparam wr_code_t WR_EBP  = 4'd1;
  localparam wr_code_t WR_ESP  = 4'd2;
  localparam wr_code_t WR_EIP  = 4'd3;
  localparam wr_code_t WR_PUSH = 4'd4;
  localparam wr_code_t WR_POP  = 4'd5;

  localparam logic [2:0] PH_READ1   = 3'd2;
  localparam logic [2:0] PH_COMMIT1 = 3'd3;
  localparam logic [2:0] PH_READ2   = 3'd4;
  localparam logic [2:0] PH_COMMIT2 = 3'd5;
  localparam logic [2:0] PH_READ3   = 3'd6;
  localparam logic [2:0] PH_LAST    = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam word_t STACK_STEP = 32'd4;

  function automatic logic is_eip_write(input wr_code_t code);
    return code == WR_EIP;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// IDLE/RUN sequencer: an 8-cycle count per instruction, with the selector
// phase strobes and the busy/done status derived from it.
module phase_counter
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] count,
  output logic       accept,
  output logic       clock_3,
  output logic       clock_5,
  output logic       clock_7,
  output logic       busy,
  output logic       done
);

  logic [0:0] state;
  logic       run;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            count <= '0;
          end
        end
        ST_RUN: begin
          if (count == PH_LAST) state <= ST_IDLE;
          count <= count + 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign run     = (state == ST_RUN);
  assign accept  = (state == ST_IDLE) && start;
  assign clock_3 = run && (count == PH_READ1);
  assign clock_5 = run && (count == PH_READ2);
  assign clock_7 = run && (count == PH_READ3);
  assign busy    = run;
  assign done    = run && (count == PH_LAST);

endmodule

// File: rtl/register_writer.sv
// Owns eip/ebp/esp and commits datapath results into them at the end of each
// phase of an instruction sequenced by phase_counter.
module register_writer
  import cpu_pkg::*;
#(
  parameter word_t RESET_EIP = 32'h0000_0000,
  parameter word_t RESET_SP  = 32'h0000_0400,
  parameter word_t EIP_STEP  = 32'd4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     start,
  input  wr_code_t write_1,
  input  wr_code_t write_2,
  input  wr_code_t write_3,
  input  word_t    wb_data,
  output logic     clock_3,
  output logic     clock_5,
  output logic     clock_7,
  output word_t    eip,
  output word_t    ebp,
  output word_t    esp,
  output logic     busy,
  output logic     done
);

  logic [2:0] count;
  logic       accept;
  wr_code_t   code_1, code_2, code_3;
  wr_code_t   phase_code;
  logic       step_blocked;

  phase_counter u_phase_counter (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .count   (count),
    .accept  (accept),
    .clock_3 (clock_3),
    .clock_5 (clock_5),
    .clock_7 (clock_7),
    .busy    (busy),
    .done    (done)
  );

  // Only one latched code is live on any commit edge, so a single decoder serves all phases.
  always_comb begin
    phase_code = WR_NONE;
    if (busy) begin
      case (count)
        PH_COMMIT1: phase_code = code_1;
        PH_COMMIT2: phase_code = code_2;
        PH_LAST:    phase_code = code_3;
        default:    phase_code = WR_NONE;
      endcase
    end
  end

  assign step_blocked = is_eip_write(code_1) || is_eip_write(code_2) || is_eip_write(code_3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_1 <= WR_NONE;
      code_2 <= WR_NONE;
      code_3 <= WR_NONE;
      eip    <= RESET_EIP;
      ebp    <= RESET_SP;
      esp    <= RESET_SP;
    end else begin
      if (accept) begin
        code_1 <= write_1;
        code_2 <= write_2;
        code_3 <= write_3;
      end
      case (phase_code)
        WR_EBP:  ebp <= wb_data;
        WR_ESP:  esp <= wb_data;
        WR_EIP:  eip <= wb_data;
        WR_PUSH: esp <= esp - STACK_STEP;
        WR_POP:  esp <= esp + STACK_STEP;
        default: ;
      endcase
      // A step is only taken when no phase wrote eip, so it never collides with WR_EIP.
      if (done && !step_blocked) eip <= eip + EIP_STEP;
    end
  end

endmodule

// File: tb/tb_register_writer.sv
// Self-checking bench for register_writer: per-instruction expected register
// values are queued at issue and compared once the instruction completes.
module tb_register_writer;
  import cpu_pkg::*;

  logic     clock = 1'b0;
  logic     reset;
  logic     start;
  wr_code_t write_1, write_2, write_3;
  word_t    wb_data;
  logic     clock_3, clock_5, clock_7;
  word_t    eip, ebp, esp;
  logic     busy, done;

  typedef struct {
    word_t eip;
    word_t ebp;
    word_t esp;
  } regs_t;

  regs_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  word_t m_eip, m_ebp, m_esp;

  always #5 clock = ~clock;

  register_writer #(
    .RESET_EIP (32'h0000_0000),
    .RESET_SP  (32'h0000_0400),
    .EIP_STEP  (32'd4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .write_1 (write_1),
    .write_2 (write_2),
    .write_3 (write_3),
    .wb_data (wb_data),
    .clock_3 (clock_3),
    .clock_5 (clock_5),
    .clock_7 (clock_7),
    .eip     (eip),
    .ebp     (ebp),
    .esp     (esp),
    .busy    (busy),
    .done    (done)
  );

  function automatic void m_reset();
    m_eip = 32'h0000_0000;
    m_ebp = 32'h0000_0400;
    m_esp = 32'h0000_0400;
  endfunction

  function automatic void m_apply(input logic [3:0] c, input word_t wb);
    case (c)
      4'd1: m_ebp = wb;
      4'd2: m_esp = wb;
      4'd3: m_eip = wb;
      4'd4: m_esp = m_esp - 32'd4;
      4'd5: m_esp = m_esp + 32'd4;
      default: ;
    endcase
  endfunction

  // Issues one instruction from an IDLE negedge and returns at the first IDLE negedge after done.
  task automatic run_instr(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                           input word_t w1, input word_t w2, input word_t w3,
                           input bit hold, input string name);
    regs_t      exp, got;
    int         busy_cycles;
    logic [3:0] exp_s, got_s;
    busy_cycles = 0;
    m_apply(c1, w1);
    m_apply(c2, w2);
    m_apply(c3, w3);
    if (c1 != 4'd3 && c2 != 4'd3 && c3 != 4'd3) m_eip = m_eip + 32'd4;
    exp = '{eip: m_eip, ebp: m_ebp, esp: m_esp};
    sb_q.push_back(exp);

    start   = 1'b1;
    write_1 = c1;
    write_2 = c2;
    write_3 = c3;
    @(negedge clock);
    if (!hold) start = 1'b0;
    write_1 = 4'($urandom);
    write_2 = 4'($urandom);
    write_3 = 4'($urandom);
    for (int k = 0; k < 8; k++) begin
      exp_s = {(k == 2), (k == 4), (k == 6), (k == 7)};
      got_s = {clock_3, clock_5, clock_7, done};
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL %s strobes@count%0d: got %b expected %b", name, k, got_s, exp_s);
      end
      if (busy === 1'b1) busy_cycles++;
      wb_data = (k == 3) ? w1 : (k == 5) ? w2 : (k == 7) ? w3 : word_t'($urandom);
      @(negedge clock);
    end
    start = 1'b0;

    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after: busy/done got %b expected 00", name, {busy, done});
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected 8", name, busy_cycles);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected 1 entry", name);
    end else begin
      got = '{eip: eip, ebp: ebp, esp: esp};
      exp = sb_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s regs: got eip=%h ebp=%h esp=%h expected eip=%h ebp=%h esp=%h",
                 name, got.eip, got.ebp, got.esp, exp.eip, exp.ebp, exp.esp);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({eip, ebp, esp} !== {32'h0, 32'h400, 32'h400}) begin
      errors++;
      $display("FAIL %s regs: got eip=%h ebp=%h esp=%h expected eip=00000000 ebp=00000400 esp=00000400",
               name, eip, ebp, esp);
    end
    checks++;
    if ({clock_3, clock_5, clock_7, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL %s status: got %b expected 00000", name, {clock_3, clock_5, clock_7, busy, done});
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    write_1 = '0;
    write_2 = '0;
    write_3 = '0;
    wb_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    m_reset();
    @(negedge clock);
    check_reset_values("reset");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      wb_data = word_t'($urandom);
      write_1 = 4'd3;
      @(negedge clock);
      checks++;
      if ({clock_3, clock_5, clock_7, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL idle_quiet@%0d: got %b expected 00000", i, {clock_3, clock_5, clock_7, busy, done});
      end
    end
    check_reset_values("idle_regs");
  endtask

  task automatic test_basic();
    run_instr(4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, "basic");
    checks++;
    if (eip !== 32'h4) begin
      errors++;
      $display("FAIL basic_eip: got %h expected 00000004", eip);
    end
  endtask

  task automatic test_push_ebp();
    run_instr(4'd4, 4'd1, 4'd0, 32'hAAAA_0001, 32'h0000_1234, 32'hBBBB_0002, 1'b0, "push_ebp");
  endtask

  task automatic test_eip_write();
    run_instr(4'd0, 4'd0, 4'd3, 32'h1, 32'h2, 32'h0000_0080, 1'b0, "eip_write");
    checks++;
    if (eip !== 32'h80) begin
      errors++;
      $display("FAIL eip_write_exact: got %h expected 00000080", eip);
    end
    run_instr(4'd3, 4'd0, 4'd0, 32'h0000_1000, 32'h2, 32'h3, 1'b0, "eip_write_ph1");
  endtask

  task automatic test_back_to_back();
    run_instr(4'd2, 4'd0, 4'd0, 32'h0, 32'h5, 32'h6, 1'b0, "esp_zero");
    run_instr(4'd0, 4'd4, 4'd0, 32'h7, 32'h8, 32'h9, 1'b0, "push_wrap");
    checks++;
    if (esp !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL push_wrap_esp: got %h expected fffffffc", esp);
    end
    run_instr(4'd0, 4'd0, 4'd5, 32'h7, 32'h8, 32'h9, 1'b0, "pop_wrap");
    checks++;
    if (esp !== 32'h0) begin
      errors++;
      $display("FAIL pop_wrap_esp: got %h expected 00000000", esp);
    end
    run_instr(4'd7, 4'd15, 4'd6, 32'h11, 32'h22, 32'h33, 1'b0, "noop_codes");
    run_instr(4'd1, 4'd2, 4'd4, 32'hCAFE_0000, 32'h0000_2000, 32'h44, 1'b0, "mixed");
  endtask

  task automatic test_reset_mid_run();
    start   = 1'b1;
    write_1 = 4'd1;
    write_2 = 4'd0;
    write_3 = 4'd0;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wb_data = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clock);
    end
    checks++;
    if ({ebp, clock_5} !== {32'hDEAD_BEEF, 1'b1}) begin
      errors++;
      $display("FAIL mid_run_commit: got ebp=%h clock_5=%b expected ebp=deadbeef clock_5=1", ebp, clock_5);
    end
    reset = 1'b1;
    #1;
    check_reset_values("reset_async");
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    @(negedge clock);
    check_reset_values("reset_release");
    run_instr(4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, "after_reset");
  endtask

  task automatic test_start_held();
    run_instr(4'd5, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b1, "start_held");
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_held_no_restart: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_push_ebp();
    test_eip_write();
    test_back_to_back();
    test_reset_mid_run();
    test_start_held();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_writer.md
# register_writer

Write-back and phase-sequencing block for the CPU core: it owns the `eip`, `ebp` and `esp` registers and generates the three phase strobes that drive the operand selector. It also commits the data returned by the datapath into the register chosen for each phase. It sits on the opposite side of the selector: the selector reads these registers onto the operand bus, and this block writes results back into them.

## Interface
Parameters:
- `RESET_EIP`, 32'h0000_0000, value loaded into `eip` at reset
- `RESET_SP`, 32'h0000_0400, value loaded into `esp` and `ebp` at reset
- `EIP_STEP`, 4, amount added to `eip` at end of instruction

Ports:
- `clock`  in  1  single system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin one instruction sequence; sampled only in IDLE
- `write_1`  in  4  write code for phase 1 (commit at count 3)
- `write_2`  in  4  write code for phase 2 (commit at count 5)
- `write_3`  in  4  write code for phase 3 (commit at count 7)
- `wb_data`  in  32  write-back value from datapath
- `clock_3`, `clock_5`, `clock_7`  out  1 each  phase strobes to selector
- `eip`, `ebp`, `esp`  out  32 each  architectural registers
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse on last RUN cycle

## Operation
- States: IDLE, RUN. 3-bit `count` is meaningful only in RUN.
- IDLE + `start`=1: latch `write_1..3` into internal copies, `count`<=0, go to RUN. `start` while in RUN is ignored.
- RUN: `count` increments each cycle. At `count`==7, return to IDLE.
- Strobes, combinational from state/count, one-hot:
  - `clock_3` = RUN && count==2
  - `clock_5` = RUN && count==4
  - `clock_7` = RUN && count==6
- Commit on the rising edge that ends count 3 (latched code 1), count 5 (code 2) and count 7 (code 3). `wb_data` is sampled at that edge.
- Write codes:
  - 0: none
  - 1: `ebp`<=`wb_data`
  - 2: `esp`<=`wb_data`
  - 3: `eip`<=`wb_data`
  - 4: `esp`<=`esp`-4 (push)
  - 5: `esp`<=`esp`+4 (pop)
  - 6–15: no-op
- End of instruction, on the edge ending count 7: `eip`<=`eip`+`EIP_STEP`, unless any latched code equals 3. A code-3 write always takes priority over the step.
- Arithmetic is modulo 2^32. 32'h0 push gives 32'hFFFF_FFFC; 32'hFFFF_FFFC pop gives 32'h0.
- Only one code is applied per phase, so there is no same-edge write conflict between phases.

## Timing
- Reset values: state IDLE, `count`=0, `eip`=`RESET_EIP`, `esp`=`ebp`=`RESET_SP`, all strobes/`busy`/`done` = 0.
- `busy`=1 from the cycle after `start` is accepted through count 7, i.e. 8 cycles.
- `done`=RUN && count==7, combinational.
- Register updates are visible the cycle after the commit edge. The selector therefore reads pre-commit values during the matching strobe.
- Back-to-back operation: `start` asserted in the first IDLE cycle after `done` is accepted, giving one idle bubble between instructions.
- Changes to `write_*` after `start` has been accepted have no effect.
- `reset` asserted mid-RUN: all outputs return to their reset values immediately. No partial commit occurs.

## Structure
- Shared package `cpu_pkg` holds:
  - write-code localparams `WR_NONE`, `WR_EBP`, `WR_ESP`, `WR_EIP`, `WR_PUSH`, `WR_POP`
  - phase constants `PH_READ1`=2, `PH_READ2`=4, `PH_READ3`=6, `PH_LAST`=7
  - the 32-bit word typedef
- One sub-module, `phase_counter`, owns the IDLE/RUN state, `count`, the strobes, `busy` and `done`. `register_writer` instantiates it and holds the three registers and the commit logic.

## Test plan
- Reset, then idle: `eip`=0, `esp`=`ebp`=32'h400. Strobes never pulse without `start`.
- `start` with codes 0/0/0: `clock_3`/`clock_5`/`clock_7` each high exactly 1 cycle, at 2/4/6 cycles after entry. `done` pulses at count 7; afterwards `eip`=4 and `busy` is low.
- Codes 4/1/0 with `wb_data`=32'h1234 at the count-5 edge: `esp`=32'h3FC, `ebp`=32'h1234, `eip`=4.
- Code3=3 with `wb_data`=32'h80: `eip`=32'h80 exactly; no +4 step.
- `esp` forced to 0 via code 2 with `wb_data`=0, then a push in the next instruction: `esp`=32'hFFFF_FFFC. A pop in the following instruction returns it to 0.
- `reset` pulsed at count 4 after a code-1 write at count 3: registers return to reset values, `busy`=0, and a new `start` completes normally. Also check `start` held high during RUN: no restart, and exactly 8 busy cycles.
